// File: rtl/pipelined_adder_sub_if.sv
// Valid/ready operand and result bundle for pipelined_adder_sub.
// Optional feature macro: ADDER_OVERFLOW_EN (adds io_out_overflow).
interface pipelined_adder_sub_if #(
  parameter int WIDTH = 16
);
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_a;
  logic [WIDTH-1:0] io_in_b;
  logic             io_in_carryIn;
  logic             io_in_sub;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_out_sum;
  logic             io_out_carryOut;
`ifdef ADDER_OVERFLOW_EN
  logic             io_out_overflow;
`endif

  modport slave (
    input  io_in_valid,
    output io_in_ready,
    input  io_in_a,
    input  io_in_b,
    input  io_in_carryIn,
    input  io_in_sub,
    output io_out_valid,
    input  io_out_ready,
    output io_out_sum,
    output io_out_carryOut
`ifdef ADDER_OVERFLOW_EN
    , output io_out_overflow
`endif
  );

  modport master (
    output io_in_valid,
    input  io_in_ready,
    output io_in_a,
    output io_in_b,
    output io_in_carryIn,
    output io_in_sub,
    input  io_out_valid,
    output io_out_ready,
    input  io_out_sum,
    input  io_out_carryOut
`ifdef ADDER_OVERFLOW_EN
    , input io_out_overflow
`endif
  );
endinterface

// File: rtl/pipelined_adder_sub.sv
// Pipelined ripple-carry adder/subtractor: STAGES chunks of WIDTH/STAGES bits, carry registered between stages.
// Optional feature macro: ADDER_OVERFLOW_EN (registered signed-overflow output).
module pipelined_adder_sub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  pipelined_adder_sub_if.slave io
);
  localparam int CW = WIDTH / STAGES;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_adder_sub: need 1 <= STAGES <= WIDTH with WIDTH divisible by STAGES");
  end

  logic             advance;

  // Per-stage inputs: stage 0 sees the ports, stage k sees the registers of stage k-1.
  logic [WIDTH-1:0] a_src   [STAGES];
  logic [WIDTH-1:0] b_src   [STAGES];
  logic [WIDTH-1:0] sum_src [STAGES];
  logic             c_src   [STAGES];
  logic             v_src   [STAGES];

  logic [WIDTH-1:0] sum_d   [STAGES];
  logic             carry_d [STAGES];

  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic             carry_q [STAGES];
  logic             valid_q [STAGES];

  // The whole pipe moves together; a stalled output freezes every stage.
  assign advance        = !valid_q[STAGES-1] || io.io_out_ready;
  assign io.io_in_ready = advance;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [CW:0]      chunk;
      logic [WIDTH-1:0] chunk_mask;

      if (gi == 0) begin : g_entry
        assign a_src[gi]   = io.io_in_a;
        assign b_src[gi]   = io.io_in_sub ? ~io.io_in_b : io.io_in_b;
        assign sum_src[gi] = '0;
        assign c_src[gi]   = io.io_in_carryIn ^ io.io_in_sub;
        assign v_src[gi]   = io.io_in_valid;
      end else begin : g_link
        assign a_src[gi]   = a_q[gi-1];
        assign b_src[gi]   = b_q[gi-1];
        assign sum_src[gi] = sum_q[gi-1];
        assign c_src[gi]   = carry_q[gi-1];
        assign v_src[gi]   = valid_q[gi-1];
      end

      assign chunk = {1'b0, a_src[gi][gi*CW +: CW]}
                   + {1'b0, b_src[gi][gi*CW +: CW]}
                   + {{CW{1'b0}}, c_src[gi]};

      // Drop this stage's chunk into the partially assembled result word.
      assign chunk_mask   = WIDTH'({CW{1'b1}}) << (gi * CW);
      assign sum_d[gi]    = (sum_src[gi] & ~chunk_mask) | (WIDTH'(chunk[CW-1:0]) << (gi * CW));
      assign carry_d[gi]  = chunk[CW];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        sum_q[k]   <= '0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= v_src[k];
        carry_q[k] <= carry_d[k];
        sum_q[k]   <= sum_d[k];
        a_q[k]     <= a_src[k];
        b_q[k]     <= b_src[k];
      end
    end
  end

  assign io.io_out_valid    = valid_q[STAGES-1];
  assign io.io_out_sum      = sum_q[STAGES-1];
  assign io.io_out_carryOut = carry_q[STAGES-1];

`ifdef ADDER_OVERFLOW_EN
  logic ovf_d;
  logic ovf_q;

  // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
  assign ovf_d = a_src[STAGES-1][WIDTH-1] ^ b_src[STAGES-1][WIDTH-1]
               ^ sum_d[STAGES-1][WIDTH-1] ^ carry_d[STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_d;
    end
  end

  assign io.io_out_overflow = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Scoreboard bench for pipelined_adder_sub (16-bit, 4 stages) plus a 1-stage instance.
// Build with ADDER_OVERFLOW_EN defined to also check the overflow output.
module tb_pipelined_adder_sub;
  localparam int WIDTH  = 16;
  localparam int STAGES = 4;
  localparam int BUDGET = 200;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic done  = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  always #5 clock = ~clock;

  pipelined_adder_sub_if #(.WIDTH(WIDTH)) io ();
  pipelined_adder_sub_if #(.WIDTH(WIDTH)) io1 ();

  pipelined_adder_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) u_dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  pipelined_adder_sub #(.WIDTH(WIDTH), .STAGES(1)) u_dut1 (
    .clock (clock),
    .reset (reset),
    .io    (io1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [15:0] sum, input logic cout, input logic ovf);
    exp_t e;
    e.sum  = sum;
    e.cout = cout;
    e.ovf  = ovf;
    return e;
  endfunction

  function automatic exp_t ref_model(input logic [15:0] a, input logic [15:0] b,
                                     input logic cin, input logic sub);
    logic [15:0] be;
    logic [16:0] r;
    be = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, be} + {16'd0, cin ^ sub};
    return mk_exp(r[15:0], r[16], (a[15] == be[15]) && (r[15] != a[15]));
  endfunction

  // Call just after a rising edge; returns just after the edge that accepted the operands.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic sub, input exp_t e);
    int n = 0;
    io.io_in_valid   = 1'b1;
    io.io_in_a       = a;
    io.io_in_b       = b;
    io.io_in_carryIn = cin;
    io.io_in_sub     = sub;
    @(negedge clock);
    while (!io.io_in_ready && n < BUDGET) begin
      n++;
      @(negedge clock);
    end
    if (io.io_in_ready) sb_q.push_back(e);
    else check("send_timeout", 32'(io.io_in_ready), 32'd1);
    @(posedge clock);
    #1;
    io.io_in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic sub_en);
    logic [15:0] a, b;
    logic        cin, sub;
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = 1'($urandom_range(0, 1));
    sub = sub_en ? 1'($urandom_range(0, 1)) : 1'b0;
    send(a, b, cin, sub, ref_model(a, b, cin, sub));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < BUDGET) begin
      @(posedge clock);
      n++;
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
    #1;
  endtask

  // Output monitor: pops on every output handshake, checks hold stability while stalled.
  initial begin
    exp_t        e;
    logic        held_v = 1'b0;
    logic [15:0] held_sum = '0;
    logic        held_cout = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          check("hold_valid", 32'(io.io_out_valid), 32'd1);
          check("hold_sum", 32'(io.io_out_sum), 32'(held_sum));
          check("hold_cout", 32'(io.io_out_carryOut), 32'(held_cout));
        end
        if (io.io_out_valid && io.io_out_ready) begin
          if (sb_q.size() == 0) begin
            check("spurious_out", 32'(io.io_out_valid), 32'd0);
          end else begin
            e = sb_q.pop_front();
            $display("txn sum=0x%04h cout=%0d exp_sum=0x%04h exp_cout=%0d",
                     io.io_out_sum, io.io_out_carryOut, e.sum, e.cout);
            check("sum", 32'(io.io_out_sum), 32'(e.sum));
            check("cout", 32'(io.io_out_carryOut), 32'(e.cout));
`ifdef ADDER_OVERFLOW_EN
            check("ovf", 32'(io.io_out_overflow), 32'(e.ovf));
`endif
          end
        end
        held_v    = io.io_out_valid && !io.io_out_ready;
        held_sum  = io.io_out_sum;
        held_cout = io.io_out_carryOut;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    io.io_in_valid    = 1'b0;
    io.io_in_a        = '0;
    io.io_in_b        = '0;
    io.io_in_carryIn  = 1'b0;
    io.io_in_sub      = 1'b0;
    io.io_out_ready   = 1'b1;
    io1.io_in_valid   = 1'b0;
    io1.io_in_a       = '0;
    io1.io_in_b       = '0;
    io1.io_in_carryIn = 1'b0;
    io1.io_in_sub     = 1'b0;
    io1.io_out_ready  = 1'b1;

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_valid", 32'(io.io_out_valid), 32'd0);
    check("rst_sum", 32'(io.io_out_sum), 32'd0);
    check("rst_cout", 32'(io.io_out_carryOut), 32'd0);
    check("rst_in_ready", 32'(io.io_in_ready), 32'd1);
`ifdef ADDER_OVERFLOW_EN
    check("rst_ovf", 32'(io.io_out_overflow), 32'd0);
`endif
    check("rst_s1_valid", 32'(io1.io_out_valid), 32'd0);

    // Wrap-around add and its latency: valid appears after the 4th register stage.
    @(posedge clock);
    #1;
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk_exp(16'h0000, 1'b1, 1'b0));
    for (int i = 0; i < STAGES; i++) begin
      @(negedge clock);
      check("latency_valid", 32'(io.io_out_valid), 32'(i == STAGES - 1));
    end
    @(posedge clock);
    #1;

    send(16'h0005, 16'h0007, 1'b0, 1'b1, mk_exp(16'hFFFE, 1'b0, 1'b0));
    send(16'h0005, 16'h0007, 1'b1, 1'b1, mk_exp(16'hFFFD, 1'b0, 1'b0));
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk_exp(16'h8000, 1'b0, 1'b1));
    send(16'h8000, 16'h0001, 1'b0, 1'b1, mk_exp(16'h7FFF, 1'b1, 1'b1));
    wait_drain();

    // Eight back-to-back adds must all emerge STAGES-1 edges after the last accept.
    @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++) send_rand(1'b0);
    repeat (STAGES - 1) @(posedge clock);
    @(negedge clock);
    #1;
    check("throughput_left", 32'(sb_q.size()), 32'd0);
    @(posedge clock);
    #1;

    // Fill the pipe with the output stalled, then release while a fifth operand waits.
    io.io_out_ready = 1'b0;
    for (int i = 0; i < STAGES; i++) send_rand(1'b1);
    fork
      send_rand(1'b1);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clock);
          check("stall_in_ready", 32'(io.io_in_ready), 32'd0);
          check("stall_out_valid", 32'(io.io_out_valid), 32'd1);
        end
        @(posedge clock);
        #1;
        io.io_out_ready = 1'b1;
      end
    join
    wait_drain();

    // Mixed operations under random backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) send_rand(1'b1);
        done = 1'b1;
      end
      begin
        int n = 0;
        while (!done && n < BUDGET) begin
          @(posedge clock);
          #1;
          io.io_out_ready = 1'($urandom_range(0, 1));
          n++;
        end
      end
    join
    io.io_out_ready = 1'b1;
    wait_drain();

    // Reset with three transactions in flight: all are discarded.
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) send_rand(1'b1);
    reset = 1'b1;
    sb_q.delete();
    @(posedge clock);
    @(negedge clock);
    check("rst_mid_valid", 32'(io.io_out_valid), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("no_stale_valid", 32'(io.io_out_valid), 32'd0);
    end

    // Single-stage instance: result one edge after acceptance.
    @(posedge clock);
    #1;
    io1.io_in_valid = 1'b1;
    io1.io_in_a     = 16'h7FFF;
    io1.io_in_b     = 16'h0001;
    io1.io_in_sub   = 1'b0;
    @(negedge clock);
    check("s1_in_ready", 32'(io1.io_in_ready), 32'd1);
    check("s1_pre_valid", 32'(io1.io_out_valid), 32'd0);
    @(posedge clock);
    #1;
    io1.io_in_a   = 16'h8000;
    io1.io_in_b   = 16'h0001;
    io1.io_in_sub = 1'b1;
    @(negedge clock);
    check("s1_valid_a", 32'(io1.io_out_valid), 32'd1);
    check("s1_sum_a", 32'(io1.io_out_sum), 32'h8000);
    check("s1_cout_a", 32'(io1.io_out_carryOut), 32'd0);
`ifdef ADDER_OVERFLOW_EN
    check("s1_ovf_a", 32'(io1.io_out_overflow), 32'd1);
`endif
    @(posedge clock);
    #1;
    io1.io_in_valid = 1'b0;
    @(negedge clock);
    check("s1_valid_b", 32'(io1.io_out_valid), 32'd1);
    check("s1_sum_b", 32'(io1.io_out_sum), 32'h7FFF);
    check("s1_cout_b", 32'(io1.io_out_carryOut), 32'd1);
`ifdef ADDER_OVERFLOW_EN
    check("s1_ovf_b", 32'(io1.io_out_overflow), 32'd1);
`endif
    @(negedge clock);
    check("s1_idle_valid", 32'(io1.io_out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
